lcd_segment_scanner: RTL and testbench

Reader side of the CPU's LCD display RAM. The CPU core writes segment nibbles into RAM 0x60–0x7F and drives the BP/BC/L controls; this block scans that RAM once per frame request through a dedicated read port and streams 33 column words (32 RAM columns plus the BS column) to the downstream LCD renderer over a valid/ready handshake, applying BP/BC blanking.

---
 rtl/lcd_segment_scanner.sv | 167 ++++++++++++++++
 tb/tb_lcd_segment_scanner.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_segment_scanner.sv
// lcd_segment_scanner
// Reads the LCD display RAM once per frame request and streams one column word
// per RAM column plus a trailing BS column (taken from the CPU L output) over a
// valid/ready handshake. Blanking is decided once at frame start from BP/BC.
// The read address is registered on entry to ADDR so the RAM sees it during
// ADDR and its one-cycle-latency data is ready to be captured in LATCH.

module lcd_segment_scanner #(
  parameter logic [6:0]  RAM_BASE  = 7'h60,
  parameter int unsigned RAM_WORDS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       lcd_bp,
  input  logic       lcd_bc,
  input  logic [3:0] segment_l,
  output logic [6:0] ram_rd_addr,
  input  logic [3:0] ram_rd_data,
  output logic       seg_valid,
  input  logic       seg_ready,
  output logic [5:0] seg_col,
  output logic [3:0] seg_data,
  output logic       frame_busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_LATCH = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Column index of the BS word; it is also the RAM column count.
  localparam logic [5:0] BS_COL = 6'(RAM_WORDS);

  state_e     state_q, state_d;
  logic [5:0] col_q, col_d;
  logic       pending_q, pending_d;
  logic       blank_q, blank_d;
  logic [6:0] addr_q, addr_d;
  logic       valid_q, valid_d;
  logic [5:0] scol_q, scol_d;
  logic [3:0] sdata_q, sdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [5:0] next_col_s;

  // State register and all registered outputs; reset aborts any scan in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      col_q     <= 6'd0;
      pending_q <= 1'b0;
      blank_q   <= 1'b0;
      addr_q    <= 7'd0;
      valid_q   <= 1'b0;
      scol_q    <= 6'd0;
      sdata_q   <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      pending_q <= pending_d;
      blank_q   <= blank_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      scol_q    <= scol_d;
      sdata_q   <= sdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: scan sequencing, request merging, blanking and output words.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    pending_d  = pending_q;
    blank_d    = blank_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    scol_d     = scol_q;
    sdata_d    = sdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    next_col_s = col_q + 6'd1;

    case (state_q)
      ST_IDLE: begin
        if (frame_start || pending_q) begin
          // Blanking is frozen here for the whole frame.
          blank_d   = ~lcd_bp | lcd_bc;
          col_d     = 6'd0;
          pending_d = 1'b0;
          addr_d    = RAM_BASE;
          busy_d    = 1'b1;
          state_d   = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ADDR: begin
        pending_d = pending_q | frame_start;
        state_d   = ST_LATCH;
      end

      ST_LATCH: begin
        pending_d = pending_q | frame_start;
        if (blank_q) begin
          sdata_d = 4'd0;
        end else if (col_q < BS_COL) begin
          sdata_d = ram_rd_data;
        end else begin
          sdata_d = segment_l;
        end
        scol_d  = col_q;
        valid_d = 1'b1;
        state_d = ST_EMIT;
      end

      ST_EMIT: begin
        pending_d = pending_q | frame_start;
        if (seg_ready) begin
          valid_d = 1'b0;
          col_d   = next_col_s;
          if (col_q == BS_COL) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ADDR;
            // The BS column has no RAM read, so the address is left alone.
            if (next_col_s < BS_COL) begin
              addr_d = 7'(RAM_BASE + {1'b0, next_col_s});
            end else begin
              addr_d = addr_q;
            end
          end
        end else begin
          state_d = ST_EMIT;
        end
      end

      ST_DONE: begin
        pending_d = pending_q | frame_start;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ram_rd_addr = addr_q;
  assign seg_valid   = valid_q;
  assign seg_col     = scol_q;
  assign seg_data    = sdata_q;
  assign frame_busy  = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_lcd_segment_scanner.sv
// Directed bench for lcd_segment_scanner: models a 1-cycle-latency RAM,
// captures accepted words and key event cycles, and compares them against
// hand-computed expectations.

module tb_lcd_segment_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       lcd_bp = 1'b1;
  logic       lcd_bc = 1'b0;
  logic [3:0] segment_l = 4'hA;
  logic [6:0] ram_rd_addr;
  logic [3:0] ram_rd_data = 4'd0;
  logic       seg_valid;
  logic       seg_ready = 1'b1;
  logic [5:0] seg_col;
  logic [3:0] seg_data;
  logic       frame_busy;
  logic       frame_done;

  logic [3:0] mem [0:127];
  logic       rand_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Captured events from the monitor.
  int w_col[$];
  int w_data[$];
  int addr_cycs[$];
  int vrise_cycs[$];
  int done_cycs[$];
  int stall_cnt = 0;
  int stall_err = 0;
  int addr_err = 0;

  lcd_segment_scanner dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .lcd_bp      (lcd_bp),
    .lcd_bc      (lcd_bc),
    .segment_l   (segment_l),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .seg_valid   (seg_valid),
    .seg_ready   (seg_ready),
    .seg_col     (seg_col),
    .seg_data    (seg_data),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Display RAM with one cycle of read latency.
  always @(posedge clk) ram_rd_data <= mem[ram_rd_addr];

  // Downstream ready: always high, or ~30% duty when backpressure is enabled.
  always @(posedge clk) begin
    #1;
    seg_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  // Monitor sampled mid-cycle: handshakes, stalls, address moves, event cycles.
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_busy = 1'b0;
  logic       prev_hs = 1'b0;
  logic [6:0] prev_addr = 7'd0;
  logic [5:0] prev_col = 6'd0;
  logic [3:0] prev_data = 4'd0;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_busy  = 1'b0;
      prev_hs    = 1'b0;
      prev_addr  = 7'd0;
    end else begin
      if (prev_valid && !prev_ready) begin
        stall_cnt++;
        if (!(seg_valid && seg_col == prev_col && seg_data == prev_data)) stall_err++;
      end
      if (ram_rd_addr != prev_addr && !(prev_hs || !prev_busy)) addr_err++;
      if (!prev_busy && frame_busy) addr_cycs.push_back(cyc);
      if (seg_valid && !prev_valid) vrise_cycs.push_back(cyc);
      if (seg_valid && seg_ready) begin
        w_col.push_back(int'(seg_col));
        w_data.push_back(int'(seg_data));
      end
      if (frame_done) done_cycs.push_back(cyc);
      prev_valid = seg_valid;
      prev_ready = seg_ready;
      prev_busy  = frame_busy;
      prev_hs    = seg_valid && seg_ready;
      prev_addr  = ram_rd_addr;
      prev_col   = seg_col;
      prev_data  = seg_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    else return -1000;
  endfunction

  task automatic pulse_start();
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int k = 0;
    while (done_cycs.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done_cycs.size(), n);
  endtask

  // Compare the 33 words captured from index wbase against the test pattern.
  task automatic check_frame(input int wbase, input logic blank);
    int exp_d;
    check("nwords", w_col.size() - wbase, 33);
    for (int i = 0; i < 33; i++) begin
      if (wbase + i < w_col.size()) begin
        if (blank) exp_d = 0;
        else if (i < 32) exp_d = i % 16;
        else exp_d = 32'hA;
        check("col", w_col[wbase + i], i);
        check("data", w_data[wbase + i], exp_d);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"}, ram_rd_addr, 0);
    check({tag, "_valid"}, seg_valid, 0);
    check({tag, "_col"}, seg_col, 0);
    check({tag, "_data"}, seg_data, 0);
    check({tag, "_busy"}, frame_busy, 0);
    check({tag, "_done"}, frame_done, 0);
  endtask

  initial begin
    int wb, ab, db, vb, sc, k;
    logic found;

    for (int i = 0; i < 128; i++) mem[i] = 4'hF;
    for (int i = 0; i < 32; i++) mem[7'h60 + i] = 4'(i);

    // Reset state.
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    // Unblanked frame with timing checks.
    wb = w_col.size(); ab = addr_cycs.size(); db = done_cycs.size(); vb = vrise_cycs.size();
    pulse_start();
    repeat (10) @(negedge clk);
    check("busy_mid", frame_busy, 1);
    wait_dones(db + 1, 300);
    check_frame(wb, 1'b0);
    check("frame_len", q_at(done_cycs, db) - q_at(addr_cycs, ab), 99);
    check("first_valid", q_at(vrise_cycs, vb) - q_at(addr_cycs, ab), 2);
    repeat (3) @(negedge clk);
    check("busy_after", frame_busy, 0);
    check("done_once", done_cycs.size() - db, 1);

    // Blanking via BC=1, then via BP=0.
    lcd_bc = 1'b1;
    wb = w_col.size(); db = done_cycs.size();
    pulse_start();
    wait_dones(db + 1, 300);
    check_frame(wb, 1'b1);
    lcd_bc = 1'b0;
    lcd_bp = 1'b0;
    wb = w_col.size(); db = done_cycs.size();
    pulse_start();
    wait_dones(db + 1, 300);
    check_frame(wb, 1'b1);
    lcd_bp = 1'b1;

    // Mid-frame change of BP/BC must not affect the running frame.
    wb = w_col.size(); db = done_cycs.size();
    pulse_start();
    repeat (20) @(negedge clk);
    lcd_bp = 1'b0;
    lcd_bc = 1'b1;
    wait_dones(db + 1, 300);
    check_frame(wb, 1'b0);
    lcd_bp = 1'b1;
    lcd_bc = 1'b0;
    repeat (3) @(negedge clk);

    // Backpressure.
    rand_ready = 1'b1;
    wb = w_col.size(); db = done_cycs.size(); sc = stall_cnt;
    pulse_start();
    wait_dones(db + 1, 3000);
    check_frame(wb, 1'b0);
    check("stalls_seen", (stall_cnt - sc) > 0, 1);
    rand_ready = 1'b0;
    repeat (5) @(negedge clk);

    // Overlapping requests, including one during DONE.
    wb = w_col.size(); ab = addr_cycs.size(); db = done_cycs.size();
    pulse_start();
    repeat (10) @(negedge clk);
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    k = 0;
    while (!frame_done && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("done_for_overlap", frame_done, 1);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    wait_dones(db + 2, 400);
    repeat (150) @(negedge clk);
    check("overlap_dones", done_cycs.size() - db, 2);
    check_frame(wb + 33, 1'b0);
    check("overlap_words", w_col.size() - wb, 66);
    check("restart_gap", q_at(addr_cycs, ab + 1) - q_at(done_cycs, db), 2);

    // Mid-frame reset with a pending request queued.
    db = done_cycs.size();
    pulse_start();
    repeat (10) @(negedge clk);
    pulse_start();
    found = 1'b0;
    k = 0;
    while (!found && k < 300) begin
      @(negedge clk);
      k++;
      if (seg_valid && seg_col == 6'd12) found = 1'b1;
    end
    check("col12_reached", found, 1);
    reset = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (150) @(negedge clk);
    check("no_done_after_rst", done_cycs.size() - db, 0);
    check("idle_after_rst", frame_busy, 0);
    wb = w_col.size(); db = done_cycs.size();
    pulse_start();
    wait_dones(db + 1, 300);
    check_frame(wb, 1'b0);

    // Global invariants over the whole run.
    check("stall_stable", stall_err, 0);
    check("addr_only_in_addr", addr_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
